// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter family: direction encoding and
// the load-value clamp used when a parallel load exceeds the count range.
package counter_pkg;

  // Direction encoding carried on up_dn.
  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

  // Widest counter the clamp helper supports; counters are limited to this.
  localparam int unsigned CNT_MAX_W = 31;

  // Clamp a load value into 0..modulus-1. Values at or above the modulus
  // saturate to the top of the range rather than being reduced modulo N.
  function automatic logic [31:0] clamp_mod(input logic [31:0] value,
                                            input logic [31:0] modulus);
    logic [31:0] res;
    if (value >= modulus) res = modulus - 32'd1;
    else                  res = value;
    return res;
  endfunction

endpackage : counter_pkg

// File: rtl/updown_mod_counter.sv
// Modulo-N up/down counter with count enable, synchronous parallel load,
// wrap-or-saturate at the range ends, a combinational terminal-count flag
// for cascading and a registered one-cycle wrap pulse.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int MODULUS  = 64,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  // Reject widths the clamp helper cannot represent and moduli outside
  // 2..2**WIDTH; a bad instance stops elaboration.
  if (WIDTH < 1 || WIDTH > CNT_MAX_W) begin : g_bad_width
    $error("updown_mod_counter: WIDTH %0d outside 1..%0d", WIDTH, CNT_MAX_W);
  end
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("updown_mod_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end

  // Top of the count range. When MODULUS == 2**WIDTH this is all ones, and
  // the explicit compare against it (not natural overflow) drives the wrap.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;
  logic [WIDTH-1:0] load_val;
  dir_e             dir;

  assign dir      = dir_e'(up_dn);
  assign load_val = WIDTH'(clamp_mod(32'(din), 32'(MODULUS)));

  // Next-state: load beats enable; an end-of-range step either wraps with a
  // pulse or holds silently depending on SATURATE.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (dir == DIR_UP) begin
        if (count_q == MAX_VAL) begin
          if (!SATURATE) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          if (!SATURATE) begin
            count_d = MAX_VAL;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // Terminal count looks at the current direction only, so a downstream
  // stage enabled by en & tc steps on exactly the edge this stage wraps.
  assign tc = ((dir == DIR_UP) && (count_q == MAX_VAL)) ||
              ((dir == DIR_DN) && (count_q == '0));

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule : updown_mod_counter

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter. Three instances share all inputs:
// the default 6-bit/mod-64 wrapping counter, a mod-10 wrapping counter and
// a mod-10 saturating counter; each scenario checks the relevant instance.
module tb_updown_mod_counter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       en, up_dn, load;
  logic [5:0] din;

  logic [5:0] count_a;
  logic       tc_a, wrap_a;
  logic [3:0] count_b, count_c;
  logic       tc_b, wrap_b, tc_c, wrap_c;

  updown_mod_counter u_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .din(din),
    .count(count_a), .tc(tc_a), .wrap(wrap_a)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .din(din[3:0]),
    .count(count_b), .tc(tc_b), .wrap(wrap_b)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_c (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .din(din[3:0]),
    .count(count_c), .tc(tc_c), .wrap(wrap_c)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fails  = 0;
  logic [5:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int c, input bit w, input bit t);
    check_eq({tag, ".a.count"}, 32'(count_a), 32'(c));
    check_eq({tag, ".a.wrap"},  32'(wrap_a),  32'(w));
    check_eq({tag, ".a.tc"},    32'(tc_a),    32'(t));
  endtask

  task automatic chk_b(input string tag, input int c, input bit w, input bit t);
    check_eq({tag, ".b.count"}, 32'(count_b), 32'(c));
    check_eq({tag, ".b.wrap"},  32'(wrap_b),  32'(w));
    check_eq({tag, ".b.tc"},    32'(tc_b),    32'(t));
  endtask

  task automatic chk_c(input string tag, input int c, input bit w, input bit t);
    check_eq({tag, ".c.count"}, 32'(count_c), 32'(c));
    check_eq({tag, ".c.wrap"},  32'(wrap_c),  32'(w));
    check_eq({tag, ".c.tc"},    32'(tc_c),    32'(t));
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [5:0] v, input logic e, input logic u);
    load = 1'b1; din = v; en = e; up_dn = u;
    step();
    load = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; din = '0;

    // Reset state; tc follows direction while held in reset.
    #12;
    chk_a("rst_up", 0, 1'b0, 1'b0);
    up_dn = 1'b0; #1;
    chk_a("rst_dn", 0, 1'b0, 1'b1);
    up_dn = 1'b1;

    // Release on the falling edge, then count up continuously 64 steps.
    #7;
    rst = 1'b1; en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 64; i++) exp_q.push_back(6'(i % 64));
    for (int i = 1; i <= 64; i++) begin
      logic [5:0] e;
      step();
      e = exp_q.pop_front();
      chk_a($sformatf("up64_%0d", i), int'(e), (i == 64), (e == 6'd63));
    end

    // Mod-10 wrapping counter going down from 0.
    do_load(6'd0, 1'b0, 1'b1);
    en = 1'b1; up_dn = 1'b0; #1;
    chk_b("dn10_start", 0, 1'b0, 1'b1);
    for (int i = 1; i <= 11; i++) begin
      int e;
      step();
      e = (i == 11) ? 9 : 10 - i;
      chk_b($sformatf("dn10_%0d", i), e, (e == 9), (e == 0));
    end

    // Saturating mod-10: up from 7 (load ignores en), then down from 2.
    do_load(6'd7, 1'b1, 1'b1);
    chk_c("sat_ld7", 7, 1'b0, 1'b0);
    step(); chk_c("sat_up1", 8, 1'b0, 1'b0);
    step(); chk_c("sat_up2", 9, 1'b0, 1'b1);
    step(); chk_c("sat_up3", 9, 1'b0, 1'b1);
    step(); chk_c("sat_up4", 9, 1'b0, 1'b1);
    do_load(6'd2, 1'b1, 1'b0);
    chk_c("sat_ld2", 2, 1'b0, 1'b0);
    step(); chk_c("sat_dn1", 1, 1'b0, 1'b0);
    step(); chk_c("sat_dn2", 0, 1'b0, 1'b1);
    step(); chk_c("sat_dn3", 0, 1'b0, 1'b1);

    // Load behaviour: priority over en, clamp, suppression of wrap.
    do_load(6'd5, 1'b1, 1'b1);
    chk_b("ld5", 5, 1'b0, 1'b0);
    step(); chk_b("ld5_next", 6, 1'b0, 1'b0);
    do_load(6'd12, 1'b1, 1'b1);
    chk_b("ld12_clamp", 9, 1'b0, 1'b1);
    chk_c("ld12_clamp", 9, 1'b0, 1'b1);
    chk_a("ld12", 12, 1'b0, 1'b0);
    do_load(6'd3, 1'b1, 1'b1);
    chk_b("ld_over_wrap", 3, 1'b0, 1'b0);

    // Enable toggling every cycle, then a direction flip at 20.
    do_load(6'd18, 1'b1, 1'b1);
    chk_a("tog_ld18", 18, 1'b0, 1'b0);
    en = 1'b1; step(); chk_a("tog1", 19, 1'b0, 1'b0);
    en = 1'b0; step(); chk_a("tog2", 19, 1'b0, 1'b0);
    en = 1'b1; step(); chk_a("tog3", 20, 1'b0, 1'b0);
    en = 1'b0; step(); chk_a("tog4", 20, 1'b0, 1'b0);
    en = 1'b1; up_dn = 1'b1; step(); chk_a("flip_up", 21, 1'b0, 1'b0);
    up_dn = 1'b0; step(); chk_a("flip_dn1", 20, 1'b0, 1'b0);
    step(); chk_a("flip_dn2", 19, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle at count 37.
    do_load(6'd36, 1'b1, 1'b1);
    en = 1'b1; up_dn = 1'b1; step();
    chk_a("pre_rst", 37, 1'b0, 1'b0);
    #3 rst = 1'b0;
    #1 chk_a("async_rst", 0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    step(); chk_a("resume1", 1, 1'b0, 1'b0);
    step(); chk_a("resume2", 2, 1'b0, 1'b0);

    // Asynchronous reset must also kill a live wrap pulse.
    do_load(6'd63, 1'b1, 1'b1);
    step(); chk_a("wrap_live", 0, 1'b1, 1'b0);
    #3 rst = 1'b0;
    #1 chk_a("async_rst_wrap", 0, 1'b0, 1'b0);
    #2 rst = 1'b1;

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule : tb_updown_mod_counter
